preg_freelist: RTL
==================

# preg_freelist

Physical-register free list for the rename stage, sitting directly upstream of the physical register file `preg`. It hands out free physical register addresses to rename, which then become `preg` write addresses. It reclaims old mappings released at commit. On a pipeline flush it recovers every speculatively allocated register in one cycle by rolling the allocation pointer back to its committed copy.

## Interface
Parameters:
- `ALLOC_PORTS`, default 2: rename allocations per cycle.
- `FREE_PORTS`, default 2: releases per cycle, from commit.
- `FL_DEPTH`, default `PREG_NUM-32`: entries; must be a power of two.

Ports:
- `clk`  in  1  — clock.
- `reset`  in  1  — synchronous, active-high.
- `alloc_req`  in  1  — rename requests `alloc_num` registers this cycle.
- `alloc_num`  in  $clog2(ALLOC_PORTS+1)  — count requested, 0..ALLOC_PORTS.
- `alloc_ready`  out  1  — free_count ≥ ALLOC_PORTS.
- `alloc_addr`  out  ALLOC_PORTS × preg_addr_t  — next free addresses, in port order.
- `commit_num`  in  $clog2(ALLOC_PORTS+1)  — allocations retired this cycle.
- `free_valid`  in  FREE_PORTS  — per-port release strobe.
- `free_addr`  in  FREE_PORTS × preg_addr_t  — released addresses.
- `flush`  in  1  — discard all uncommitted allocations.
- `free_count`  out  $clog2(FL_DEPTH+1)  — registered count of free entries.
- `fl_err`  out  1  — sticky error flag; see Configuration.

## Operation
- Storage: circular buffer `fifo[FL_DEPTH]` of preg_addr_t.
- Pointers, each $clog2(FL_DEPTH)+1 bits with a wrap bit:
  - `head`: speculative allocate pointer.
  - `cmt_head`: committed allocate pointer.
  - `tail`: free pointer.
- Derived counts: `free_count = tail - head`; full when the index bits are equal and the wrap bits differ.
- Reset:
  - `fifo[i] = 32+i`.
  - `head = cmt_head = 0`; `tail = FL_DEPTH` (wrap bit set).
  - Outputs after reset: `free_count = FL_DEPTH`, `alloc_ready = 1`, `fl_err = 0`.
  - Pregs 0..31 hold the initial architectural mapping and are never in the list at reset.
- Allocate:
  - `alloc_addr[i] = fifo[head+i]`, combinational from registered state only.
  - When `alloc_req && alloc_ready && !flush`: `head += alloc_num`.
  - Otherwise `head` holds.
  - Allocation is all-or-nothing: a request made while `alloc_ready=0` is ignored, with no partial grant.
- Commit: `cmt_head += commit_num`. Rename/ROB guarantees that `cmt_head` never passes `head`.
- Free:
  - Valid ports are compacted in ascending port order and written at `fifo[tail]`, `fifo[tail+1]`, ….
  - `tail += popcount(free_valid)`.
  - A release of address 0 is dropped and does not advance `tail`.
- Flush:
  - `head <= cmt_head + commit_num`, so the same-cycle commit is honoured.
  - Same-cycle frees still apply; same-cycle allocation is ignored.
- Simultaneous allocate and free:
  - Both apply.
  - Entries freed this cycle cannot be allocated until the next cycle.
  - `free_count` next cycle = old − alloc_num + frees.
- Overflow: a free when the list is full is dropped, and `tail` does not move.
- All pointer arithmetic is modulo 2·FL_DEPTH; the index bits address `fifo`.

## Timing
- Zero-cycle read: `alloc_addr` is valid in the same cycle as `alloc_ready`.
- One-cycle update: pointer and count changes are visible on the edge after the request.
- Free-to-reallocate latency: 1 cycle minimum, when the list was near empty.
- Reset mid-operation:
  - Reset has priority over flush, alloc and free.
  - Reset restores the reset image regardless of in-flight state.
- `alloc_ready` and `free_count` are pure functions of registers, with no input-to-output combinational path.

## Configuration
- `FREELIST_CHECK_EN` defined:
  - `fl_err` sets (sticky until reset) on any of: free of address 0; free while full; `alloc_req` with `alloc_num > free_count`; `commit_num` that would move `cmt_head` past `head`.
  - Under `VERILATOR`, an immediate assertion also fires on each of these.
- `FREELIST_CHECK_EN` undefined:
  - `fl_err` is tied to 0 and no check logic is built.
  - Datapath behaviour is identical in both builds.

## Structure
- Shared package `common`:
  - `PREG_NUM`, `preg_addr_t`.
  - New `FL_DEPTH` constant.
  - New `fl_ptr_t` typedef (index plus wrap bit).
- Optional sub-module `freelist_compact`: a combinational popcount/prefix-sum that maps `free_valid` to write slots. All other logic stays inline.

## Test plan
- Reset, then 16 allocations of 2 with commit each cycle (PREG_NUM=64) → addresses 32..63 in order; `free_count` falls 32→0; `alloc_ready` drops when `free_count` < 2.
- From empty, free 40 and 50 in one cycle → next cycle `free_count=2`, `alloc_addr={40,50}`, `alloc_ready=1`.
- Allocate 4 with no commit, then `flush` → `head` returns to `cmt_head`; `free_count` is restored; the same 4 addresses are reissued.
- Same-cycle `alloc_num=2`, two frees, and `commit_num=1` → `free_count` unchanged next cycle; freed addresses land at tail in port-0-first order.
- Free address 0 and free while full, with `FREELIST_CHECK_EN` → both dropped, `fl_err=1`; without the macro, `fl_err` stays 0 and the pointers are unchanged.
- Assert `reset` during a flush with pending frees → next cycle matches the reset image exactly (`free_count=32`, `alloc_addr={32,33}`).

Source files
------------

// File: rtl/preg_freelist_pkg.sv
// Shared rename-stage types for the physical-register free list.
// PREG_NUM physical registers; the first ARCH_REGS hold the initial
// architectural mapping and never start out in the free list.
package preg_freelist_pkg;

  localparam int unsigned PREG_NUM  = 64;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned PREG_W    = $clog2(PREG_NUM);
  localparam int unsigned FL_DEPTH  = PREG_NUM - ARCH_REGS;

  typedef logic [PREG_W-1:0] preg_addr_t;

  // Free-list pointer: index bits plus one wrap bit.
  typedef logic [$clog2(FL_DEPTH):0] fl_ptr_t;

  // Reset contents of free-list slot i.
  function automatic preg_addr_t reset_entry(input int unsigned i);
    return preg_addr_t'(ARCH_REGS + i);
  endfunction

endpackage

// File: rtl/preg_freelist_compact.sv
// Release-port compaction: maps the per-port release strobes to
// consecutive write slots (exclusive prefix sum) and a total count.
module freelist_compact #(
  parameter int unsigned PORTS = 2,
  localparam int unsigned SW   = $clog2(PORTS + 1)
) (
  input  logic [PORTS-1:0]         valid,
  output logic [PORTS-1:0][SW-1:0] slot,
  output logic [SW-1:0]            total
);

  logic [SW-1:0] run;

  // Running count of lower-numbered valid ports gives each port its slot.
  always_comb begin
    run  = '0;
    slot = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      slot[p] = run;
      run     = run + SW'(valid[p]);
    end
    total = run;
  end

endmodule

// File: rtl/preg_freelist.sv
// Physical-register free list for rename. Circular buffer with a
// speculative allocate pointer (head), a committed allocate pointer
// (cmt_head) for single-cycle flush recovery, and a free pointer (tail).
// Optional checking: define FREELIST_CHECK_EN to build the sticky fl_err
// logic; otherwise fl_err is tied low.
module preg_freelist #(
  parameter int unsigned ALLOC_PORTS = 2,
  parameter int unsigned FREE_PORTS  = 2,
  parameter int unsigned FL_DEPTH    = preg_freelist_pkg::FL_DEPTH
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          alloc_req,
  input  logic [$clog2(ALLOC_PORTS+1)-1:0]              alloc_num,
  output logic                                          alloc_ready,
  output preg_freelist_pkg::preg_addr_t [ALLOC_PORTS-1:0] alloc_addr,
  input  logic [$clog2(ALLOC_PORTS+1)-1:0]              commit_num,
  input  logic [FREE_PORTS-1:0]                         free_valid,
  input  preg_freelist_pkg::preg_addr_t [FREE_PORTS-1:0]  free_addr,
  input  logic                                          flush,
  output logic [$clog2(FL_DEPTH+1)-1:0]                 free_count,
  output logic                                          fl_err
);

  import preg_freelist_pkg::*;

  localparam int unsigned IDX_W  = $clog2(FL_DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned CNT_W  = $clog2(FL_DEPTH + 1);
  localparam int unsigned SLOT_W = $clog2(FREE_PORTS + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [IDX_W-1:0] idx_t;

  preg_addr_t fifo [FL_DEPTH];
  ptr_t       head;
  ptr_t       cmt_head;
  ptr_t       tail;

  ptr_t       occ;
  ptr_t       space;
  ptr_t       head_adv;
  ptr_t       head_nxt;
  ptr_t       free_adv;

  logic [FREE_PORTS-1:0]             free_live;
  logic [FREE_PORTS-1:0]             free_accept;
  logic [FREE_PORTS-1:0][SLOT_W-1:0] free_slot;
  logic [SLOT_W-1:0]                 free_total;
  idx_t [FREE_PORTS-1:0]             wr_idx;

  // Releases of preg 0 never enter the list.
  always_comb begin
    for (int unsigned p = 0; p < FREE_PORTS; p++) begin
      free_live[p] = free_valid[p] && (free_addr[p] != '0);
    end
  end

  freelist_compact #(
    .PORTS (FREE_PORTS)
  ) u_compact (
    .valid (free_live),
    .slot  (free_slot),
    .total (free_total)
  );

  // Occupancy, room for releases, and the next allocate pointer.
  always_comb begin
    occ         = tail - head;
    space       = ptr_t'(FL_DEPTH) - occ;
    free_count  = CNT_W'(occ);
    alloc_ready = (occ >= ptr_t'(ALLOC_PORTS));
    head_adv    = head;
    if (alloc_req && alloc_ready && !flush) begin
      head_adv = head + ptr_t'(alloc_num);
    end
    head_nxt = flush ? (cmt_head + ptr_t'(commit_num)) : head_adv;
    free_adv = (ptr_t'(free_total) > space) ? space : ptr_t'(free_total);
  end

  // Per-port accept (slots past the remaining room overflow) and write index.
  always_comb begin
    for (int unsigned p = 0; p < FREE_PORTS; p++) begin
      free_accept[p] = free_live[p] && (ptr_t'(free_slot[p]) < space);
      wr_idx[p]      = tail[IDX_W-1:0] + IDX_W'(free_slot[p]);
    end
  end

  // Next free addresses, read purely from registered state.
  always_comb begin
    idx_t rd_idx;
    rd_idx     = '0;
    alloc_addr = '0;
    for (int unsigned i = 0; i < ALLOC_PORTS; i++) begin
      rd_idx        = head[IDX_W-1:0] + IDX_W'(i);
      alloc_addr[i] = fifo[rd_idx];
    end
  end

  // Pointer update; flush rolls head back to the committed copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      cmt_head <= '0;
      tail     <= ptr_t'(FL_DEPTH);
    end else begin
      head     <= head_nxt;
      cmt_head <= cmt_head + ptr_t'(commit_num);
      tail     <= tail + free_adv;
    end
  end

  // Storage: reset image, then compacted releases written at tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        fifo[i] <= reset_entry(i);
      end
    end else begin
      for (int unsigned p = 0; p < FREE_PORTS; p++) begin
        if (free_accept[p]) begin
          fifo[wr_idx[p]] <= free_addr[p];
        end
      end
    end
  end

`ifdef FREELIST_CHECK_EN
  logic err_zero;
  logic err_full;
  logic err_alloc;
  logic err_commit;
  ptr_t inflight;

  // Protocol violations seen this cycle.
  always_comb begin
    err_zero = 1'b0;
    for (int unsigned p = 0; p < FREE_PORTS; p++) begin
      if (free_valid[p] && (free_addr[p] == '0)) begin
        err_zero = 1'b1;
      end
    end
    err_full   = |(free_live & ~free_accept);
    err_alloc  = alloc_req && (ptr_t'(alloc_num) > occ);
    inflight   = head_adv - cmt_head;
    err_commit = (ptr_t'(commit_num) > inflight);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fl_err <= 1'b0;
    end else if (err_zero || err_full || err_alloc || err_commit) begin
      fl_err <= 1'b1;
    end
  end

  // Immediate checks mirroring each fl_err source.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!err_zero)   else $error("preg_freelist: release of preg 0");
      assert (!err_full)   else $error("preg_freelist: release while full");
      assert (!err_alloc)  else $error("preg_freelist: alloc_num exceeds free_count");
      assert (!err_commit) else $error("preg_freelist: commit passes head");
    end
  end
`else
  assign fl_err = 1'b0;
`endif

endmodule
